// File: rtl/bg_rom_arbiter.sv
// Shares one pixel-ROM port between display (D) and aux (A) readers; read data returns ROM_LAT+2 cycles after accept, tagged to its requester.
// Blanking arbitration is round-robin when ARB_ROUND_ROBIN_EN is defined, fixed display priority otherwise.
module bg_rom_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int ROM_LAT      = 1,
  parameter int STARVE_LIMIT = 800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bright,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_data,
  output logic              aux_valid,
  output logic              aux_starved,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_ACTIVE    = 2'd0,
    S_BLANK     = 2'd1,
    S_FORCE_AUX = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_disp_pick;
  logic              w_aux_pick;
  logic              w_disp_acc;
  logic              w_aux_acc;
  logic              w_acc;
  logic [ROM_LAT:0]  r_tag_vld;
  logic [ROM_LAT:0]  r_tag_aux;
  logic              r_starved;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_en;
  logic [DATA_W-1:0] r_disp_data;
  logic [DATA_W-1:0] r_aux_data;
  logic              r_disp_valid;
  logic              r_aux_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic              r_last_aux;
`endif

  // Only the forced slot is remembered; otherwise bright picks the state in the same cycle.
  always_comb begin
    w_state     = bright ? S_ACTIVE : S_BLANK;
    w_disp_pick = 1'b0;
    w_aux_pick  = 1'b0;
    if (r_state == S_FORCE_AUX) begin
      w_state = S_FORCE_AUX;
    end
    case (w_state)
      S_FORCE_AUX: begin
        w_aux_pick = aux_req;
      end
      S_BLANK: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (disp_req && aux_req) begin
          w_disp_pick = r_last_aux;
          w_aux_pick  = !r_last_aux;
        end else begin
          w_disp_pick = disp_req;
          w_aux_pick  = aux_req;
        end
`else
        w_disp_pick = disp_req;
        w_aux_pick  = aux_req && !disp_req;
`endif
      end
      default: begin
        w_disp_pick = disp_req;
        w_aux_pick  = aux_req && !disp_req;
      end
    endcase
  end

  assign disp_gnt   = w_disp_pick && !reset;
  assign aux_gnt    = w_aux_pick && !reset;
  assign w_disp_acc = disp_req && disp_gnt;
  assign w_aux_acc  = aux_req && aux_gnt;
  assign w_acc      = w_disp_acc || w_aux_acc;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!aux_req || w_aux_acc) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != LIMIT) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = bright ? S_ACTIVE : S_BLANK;
    if (w_state != S_FORCE_AUX && !bright && w_cnt_nxt == LIMIT) begin
      w_state_nxt = S_FORCE_AUX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_BLANK;
      r_cnt     <= '0;
      r_starved <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_aux_acc) begin
        r_starved <= 1'b0;
      end else if (bright && r_cnt == LIMIT) begin
        r_starved <= 1'b1;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_aux <= 1'b1;
    end else if (w_acc) begin
      r_last_aux <= w_aux_acc;
    end
  end
`endif

  // Tag stage ROM_LAT lines up with the cycle rom_data is valid for that read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr   <= '0;
      r_rom_en     <= 1'b0;
      r_tag_vld    <= '0;
      r_tag_aux    <= '0;
      r_disp_data  <= '0;
      r_aux_data   <= '0;
      r_disp_valid <= 1'b0;
      r_aux_valid  <= 1'b0;
    end else begin
      r_rom_en  <= w_acc;
      if (w_acc) begin
        r_rom_addr <= w_aux_acc ? aux_addr : disp_addr;
      end
      r_tag_vld <= {r_tag_vld[ROM_LAT-1:0], w_acc};
      r_tag_aux <= {r_tag_aux[ROM_LAT-1:0], w_aux_acc};
      r_disp_valid <= r_tag_vld[ROM_LAT] && !r_tag_aux[ROM_LAT];
      r_aux_valid  <= r_tag_vld[ROM_LAT] && r_tag_aux[ROM_LAT];
      if (r_tag_vld[ROM_LAT] && !r_tag_aux[ROM_LAT]) begin
        r_disp_data <= rom_data;
      end
      if (r_tag_vld[ROM_LAT] && r_tag_aux[ROM_LAT]) begin
        r_aux_data <= rom_data;
      end
    end
  end

  assign rom_addr    = r_rom_addr;
  assign rom_en      = r_rom_en;
  assign disp_data   = r_disp_data;
  assign disp_valid  = r_disp_valid;
  assign aux_data    = r_aux_data;
  assign aux_valid   = r_aux_valid;
  assign aux_starved = r_starved;

endmodule
